// File: rtl/key_counter_ctrl_if.sv
// Control and status bundle of the key-controlled pattern counter.
// The master drives the raw keys and the clear strobe; the slave (the counter)
// returns the count value and its mode flags.
interface key_counter_ctrl_if #(
  parameter int WIDTH = 48
);
  logic             key_run_n;
  logic             key_step_n;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             dir_down;
  logic             wrap_pulse;

  modport master (
    output key_run_n,
    output key_step_n,
    output clear,
    input  count,
    input  running,
    input  dir_down,
    input  wrap_pulse
  );

  modport slave (
    input  key_run_n,
    input  key_step_n,
    input  clear,
    output count,
    output running,
    output dir_down,
    output wrap_pulse
  );
endinterface

// File: rtl/key_counter_ctrl.sv
// Free-running pattern counter driven by two raw push-buttons.
// Each key is synchronised, debounced and edge-detected into a one-cycle press
// pulse. The run key toggles RUN/PAUSE; the step key single-steps while paused
// and reverses direction while running. Limits either wrap (with a one-cycle
// wrap_pulse) or saturate.
module key_counter_ctrl #(
  parameter int WIDTH    = 48,
  parameter int DEBOUNCE = 1000000,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0
) (
  input logic               clk_video,
  input logic               reset,
  key_counter_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DW-1:0]    DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0]    PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_PAUSE = 1'b1
  } state_t;

  // Index 0 = run key, index 1 = step key.
  logic [1:0] key_raw;
  logic [1:0] key_press;

  assign key_raw = {bus.key_step_n, bus.key_run_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          press_reg;
      logic [DW-1:0] db_cnt_reg;

      // Synchronise the raw level, accept it once it has held long enough,
      // and emit a single-cycle pulse on an accepted press (1 -> 0).
      always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
          sync1_reg  <= 1'b1;
          sync2_reg  <= 1'b1;
          stable_reg <= 1'b1;
          press_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
            press_reg  <= ~sync2_reg;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      assign key_press[gi] = press_reg;
    end
  endgenerate

  logic run_press;
  logic step_press;

  assign run_press  = key_press[0];
  assign step_press = key_press[1];

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             dir_reg, dir_next;
  logic             wrap_reg, wrap_next;
  logic             advance;

  // Mode control: run/pause toggling, prescaler and the advance request.
  // A run press in the same cycle as a step press swallows the step.
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    dir_next   = dir_reg;
    advance    = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (run_press) begin
          state_next = S_PAUSE;
          presc_next = '0;
        end else begin
          if (step_press) begin
            dir_next = ~dir_reg;
          end
          if (presc_reg == PS_LAST) begin
            presc_next = '0;
            advance    = 1'b1;
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        presc_next = '0;
        if (run_press) begin
          state_next = S_RUN;
        end else if (step_press) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_next = S_RUN;
        presc_next = '0;
      end
    endcase
    if (bus.clear) begin
      presc_next = '0;
    end
  end

  // Count datapath: clear beats advance; the direction used is the one in
  // force before any same-cycle reversal.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (bus.clear) begin
      count_next = '0;
    end else if (advance) begin
      if (!dir_reg) begin
        if (count_reg == ALL_ONES) begin
          if (!SATURATE) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (count_reg == '0) begin
          if (!SATURATE) begin
            count_next = ALL_ONES;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end
  end

  // State, prescaler and output registers.
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      state_reg <= S_RUN;
      presc_reg <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      count_reg <= count_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bus.count      = count_reg;
  assign bus.running    = (state_reg == S_RUN);
  assign bus.dir_down   = dir_reg;
  assign bus.wrap_pulse = wrap_reg;

endmodule

// File: tb/tb_key_counter_ctrl.sv
// Bench for key_counter_ctrl: one wrapping instance and one saturating
// instance (WIDTH=4, DEBOUNCE=4, PRESCALE=3). Directed key/clear stimulus
// pushes the expected sequence of count changes into a queue per instance;
// a negedge monitor pops and compares every observed count change or wrap.
module tb_key_counter_ctrl;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] val;
    logic         wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic mon0_en = 1'b1;
  logic mon1_en = 1'b1;
  logic [W-1:0] prev0 = '0;
  logic [W-1:0] prev1 = '0;

  key_counter_ctrl_if #(.WIDTH(W)) bus0 ();
  key_counter_ctrl_if #(.WIDTH(W)) bus1 ();

  key_counter_ctrl #(
    .WIDTH(W), .DEBOUNCE(4), .PRESCALE(3), .SATURATE(1'b0)
  ) u_dut_wrap (
    .clk_video(clk),
    .reset    (rst0),
    .bus      (bus0)
  );

  key_counter_ctrl #(
    .WIDTH(W), .DEBOUNCE(4), .PRESCALE(3), .SATURATE(1'b1)
  ) u_dut_sat (
    .clk_video(clk),
    .reset    (rst1),
    .bus      (bus1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push0(input int v, input logic w);
    exp_t e;
    e.val  = v[W-1:0];
    e.wrap = w;
    q0.push_back(e);
  endtask

  task automatic push1(input int v, input logic w);
    exp_t e;
    e.val  = v[W-1:0];
    e.wrap = w;
    q1.push_back(e);
  endtask

  // Advance n rising edges, then stop at the following falling edge.
  task automatic to_neg(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard for the wrapping instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon0_en && (bus0.count !== prev0 || bus0.wrap_pulse !== 1'b0)) begin
      if (q0.size() == 0) begin
        check_eq("wrap_extra_event", {bus0.wrap_pulse, bus0.count}, {1'b0, prev0});
      end else begin
        e = q0.pop_front();
        $display("[TB] wrap dut: count=%0d wrap_pulse=%0d (expected %0d/%0d)",
                 bus0.count, bus0.wrap_pulse, e.val, e.wrap);
        check_eq("wrap_count", bus0.count, e.val);
        check_eq("wrap_pulse", bus0.wrap_pulse, e.wrap);
      end
    end
    prev0 = bus0.count;
  end

  // Scoreboard for the saturating instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon1_en && (bus1.count !== prev1 || bus1.wrap_pulse !== 1'b0)) begin
      if (q1.size() == 0) begin
        check_eq("sat_extra_event", {bus1.wrap_pulse, bus1.count}, {1'b0, prev1});
      end else begin
        e = q1.pop_front();
        $display("[TB] sat dut: count=%0d wrap_pulse=%0d (expected %0d/%0d)",
                 bus1.count, bus1.wrap_pulse, e.val, e.wrap);
        check_eq("sat_count", bus1.count, e.val);
        check_eq("sat_pulse", bus1.wrap_pulse, e.wrap);
      end
    end
    prev1 = bus1.count;
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.key_run_n = 1'b1; bus0.key_step_n = 1'b1; bus0.clear = 1'b0;
    bus1.key_run_n = 1'b1; bus1.key_step_n = 1'b1; bus1.clear = 1'b0;

    // Reset state.
    to_neg(3);
    check_eq("rst_count", bus0.count, 0);
    check_eq("rst_running", bus0.running, 1);
    check_eq("rst_dir", bus0.dir_down, 0);
    check_eq("rst_wrap", bus0.wrap_pulse, 0);

    // 1: free run, one advance every 3 cycles, wrap 15 -> 0. Edge numbers
    // below (E) count rising edges after reset release.
    for (int i = 1; i <= 18; i++) push0(i % 16, (i == 16));
    rst0 = 1'b0;
    to_neg(2);                                   // E2
    check_eq("s1_before_tick", bus0.count, 0);
    to_neg(1);                                   // E3
    check_eq("s1_first_tick", bus0.count, 1);
    to_neg(51);                                  // E54
    check_eq("s1_count", bus0.count, 2);
    check_eq("s1_running", bus0.running, 1);
    check_eq("s1_dir", bus0.dir_down, 0);

    // 2: 3-cycle glitch is ignored; held press pauses 7 cycles after the fall.
    for (int v = 3; v <= 7; v++) push0(v, 1'b0);
    bus0.key_run_n = 1'b0;
    to_neg(3);                                   // E57
    bus0.key_run_n = 1'b1;
    to_neg(6);                                   // E63
    check_eq("s2_glitch_running", bus0.running, 1);
    bus0.key_run_n = 1'b0;
    to_neg(6);                                   // E69
    check_eq("s2_before_toggle", bus0.running, 1);
    to_neg(1);                                   // E70
    check_eq("s2_paused", bus0.running, 0);
    bus0.key_run_n = 1'b1;
    to_neg(12);                                  // E82
    check_eq("s2_frozen", bus0.count, 7);

    // 3: paused, three step presses, one increment each.
    for (int i = 0; i < 3; i++) begin
      push0(8 + i, 1'b0);
      bus0.key_step_n = 1'b0;
      to_neg(8);
      bus0.key_step_n = 1'b1;
      to_neg(8);
      check_eq("s3_step", bus0.count, 8 + i);
    end                                          // E130
    check_eq("s3_dir", bus0.dir_down, 0);
    check_eq("s3_still_paused", bus0.running, 0);

    // Resume: the prescaler restarts, first advance 3 cycles after the toggle.
    push0(11, 1'b0);
    bus0.key_run_n = 1'b0;
    to_neg(6);                                   // E136
    check_eq("s2_resume_wait", bus0.running, 0);
    bus0.key_run_n = 1'b1;
    to_neg(1);                                   // E137
    check_eq("s2_resumed", bus0.running, 1);
    to_neg(2);                                   // E139
    check_eq("s2_restart_hold", bus0.count, 10);
    to_neg(1);                                   // E140
    check_eq("s2_restart_tick", bus0.count, 11);

    // 4: step press in RUN reverses direction; 1, 0, 15 with a wrap.
    push0(12, 0); push0(13, 0); push0(14, 0); push0(15, 0); push0(0, 1);
    push0(1, 0);  push0(0, 0);  push0(15, 1); push0(14, 0);
    to_neg(12);                                  // E152
    bus0.key_step_n = 1'b0;
    to_neg(6);                                   // E158
    check_eq("s4_dir_before", bus0.dir_down, 0);
    check_eq("s4_at_one", bus0.count, 1);
    to_neg(1);                                   // E159
    check_eq("s4_dir_toggled", bus0.dir_down, 1);
    bus0.key_step_n = 1'b1;
    to_neg(8);                                   // E167
    check_eq("s4_down", bus0.count, 14);

    // Simultaneous run and step press: only running toggles.
    push0(13, 0); push0(12, 0);
    bus0.key_run_n  = 1'b0;
    bus0.key_step_n = 1'b0;
    to_neg(6);                                   // E173
    check_eq("s4_both_before", bus0.running, 1);
    to_neg(1);                                   // E174
    check_eq("s4_both_running", bus0.running, 0);
    check_eq("s4_both_dir", bus0.dir_down, 1);
    bus0.key_run_n  = 1'b1;
    bus0.key_step_n = 1'b1;
    to_neg(10);                                  // E184
    check_eq("s4_both_frozen", bus0.count, 12);

    // 6: clear on a tick cycle at count 7, then asynchronous reset mid-cycle.
    push0(11, 0); push0(10, 0); push0(9, 0); push0(8, 0); push0(7, 0);
    push0(0, 0);  push0(15, 1);
    bus0.key_run_n = 1'b0;
    to_neg(6);                                   // E190
    bus0.key_run_n = 1'b1;
    to_neg(1);                                   // E191
    check_eq("s6_running", bus0.running, 1);
    to_neg(17);                                  // E208
    check_eq("s6_before_clear", bus0.count, 7);
    bus0.clear = 1'b1;
    to_neg(1);                                   // E209
    bus0.clear = 1'b0;
    check_eq("s6_clear_count", bus0.count, 0);
    check_eq("s6_clear_running", bus0.running, 1);
    check_eq("s6_clear_dir", bus0.dir_down, 1);
    to_neg(2);                                   // E211
    check_eq("s6_clear_hold", bus0.count, 0);
    to_neg(1);                                   // E212
    check_eq("s6_after_clear", bus0.count, 15);
    #1;
    mon0_en = 1'b0;
    check_eq("s6_q0_drained", q0.size(), 0);
    #1;
    rst0 = 1'b1;
    #1;
    check_eq("s6_async_count", bus0.count, 0);
    check_eq("s6_async_running", bus0.running, 1);
    check_eq("s6_async_dir", bus0.dir_down, 0);
    check_eq("s6_async_wrap", bus0.wrap_pulse, 0);

    // 5: saturating instance holds at 15, then a step press turns it down.
    @(negedge clk);
    for (int v = 1; v <= 15; v++) push1(v, 1'b0);
    rst1 = 1'b0;
    to_neg(60);                                  // E60
    check_eq("s5_hold_top", bus1.count, 15);
    check_eq("s5_dir_up", bus1.dir_down, 0);
    for (int v = 14; v >= 0; v--) push1(v, 1'b0);
    bus1.key_step_n = 1'b0;
    to_neg(6);                                   // E66
    bus1.key_step_n = 1'b1;
    check_eq("s5_still_top", bus1.count, 15);
    to_neg(2);                                   // E68
    check_eq("s5_dir_down", bus1.dir_down, 1);
    check_eq("s5_before_tick", bus1.count, 15);
    to_neg(1);                                   // E69
    check_eq("s5_down_tick", bus1.count, 14);
    to_neg(57);                                  // E126
    check_eq("s5_hold_floor", bus1.count, 0);
    check_eq("s5_q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
